// File: rtl/sram_dp_bwe.sv
// Simple dual-port synchronous SRAM: one write port with byte enables, one read port
// with 1- or 2-cycle latency, selectable collision behaviour and a post-reset clear sweep.
module sram_dp_bwe #(
  parameter int ADDR_WIDTH   = 4,
  parameter int WORD_DEPTH   = 16,
  parameter int WORD_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WORD_WIDTH-1:0]   d_in,
  input  logic [WORD_WIDTH/8-1:0] be,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [WORD_WIDTH-1:0]   d_out,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NUM_LANES = WORD_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("sram_dp_bwe: READ_LATENCY must be 1 or 2");
    end
    if ((WORD_WIDTH % 8) != 0) begin : g_bad_width
      $error("sram_dp_bwe: WORD_WIDTH must be a multiple of 8");
    end
    if (WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("sram_dp_bwe: WORD_DEPTH exceeds the address space");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t                  state_reg;
  logic                    busy_reg;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg;

  logic [WORD_WIDTH-1:0]   mem [WORD_DEPTH];

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    clr_we;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    fwd_hit;
  logic [WORD_WIDTH-1:0]   rd_word;

  logic                    rd_valid_p1_reg;
  logic [WORD_WIDTH-1:0]   rd_data_p1_reg;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  // rst gates the array explicitly since the array itself has no reset path
  assign clr_we      = !rst && (state_reg == ST_CLEAR);
  assign wr_ok       = !rst && (state_reg == ST_IDLE) && we && wr_in_range;
  assign rd_ok       = (state_reg == ST_IDLE) && re;
  assign fwd_hit     = (WRITE_MODE == 1) && wr_ok && (wr_addr == rd_addr);
  assign busy        = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      busy_reg    <= (INIT_CLEAR != 0);
      clr_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + ADDR_WIDTH'(1);
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            clr_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_reg] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) begin
          mem[wr_addr][8*i +: 8] <= d_in[8*i +: 8];
        end
      end
    end
  end

  // Write-first forwarding is done per lane so the array only ever sees one read address
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign rd_word[8*gi +: 8] = !rd_in_range            ? 8'h00 :
                                  (fwd_hit && be[gi])     ? d_in[8*gi +: 8] :
                                                            mem[rd_addr][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_p1_reg <= 1'b0;
      rd_data_p1_reg  <= '0;
    end else begin
      rd_valid_p1_reg <= rd_ok;
      if (rd_ok) begin
        rd_data_p1_reg <= rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  rd_valid_reg;
      logic [WORD_WIDTH-1:0] d_out_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_valid_reg <= 1'b0;
          d_out_reg    <= '0;
        end else begin
          rd_valid_reg <= rd_valid_p1_reg;
          if (rd_valid_p1_reg) begin
            d_out_reg <= rd_data_p1_reg;
          end
        end
      end

      assign d_out    = d_out_reg;
      assign rd_valid = rd_valid_reg;
    end else begin : g_lat1
      assign d_out    = rd_data_p1_reg;
      assign rd_valid = rd_valid_p1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp_bwe.sv
// Bench for sram_dp_bwe: two instances (defaults, and WM1/L2/depth 12/no clear) share stimulus
// and are checked against a word-level reference model plus a directed vector table.
module tb_sram_dp_bwe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] d_in = '0;
  logic [1:0]  be = '0;

  logic [15:0] d_out_a, d_out_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  sram_dp_bwe #(
    .ADDR_WIDTH(4), .WORD_DEPTH(16), .WORD_WIDTH(16),
    .READ_LATENCY(1), .WRITE_MODE(0), .INIT_CLEAR(1)
  ) dut_a (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .d_in(d_in), .be(be),
    .re(re), .rd_addr(rd_addr), .d_out(d_out_a), .rd_valid(rd_valid_a), .busy(busy_a)
  );

  sram_dp_bwe #(
    .ADDR_WIDTH(4), .WORD_DEPTH(12), .WORD_WIDTH(16),
    .READ_LATENCY(2), .WRITE_MODE(1), .INIT_CLEAR(0)
  ) dut_b (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .d_in(d_in), .be(be),
    .re(re), .rd_addr(rd_addr), .d_out(d_out_b), .rd_valid(rd_valid_b), .busy(busy_b)
  );

  // Model configuration per instance: index 0 = dut_a, 1 = dut_b
  int dep_p[2] = '{16, 12};
  int lat_p[2] = '{1, 2};
  int wm_p[2]  = '{0, 1};
  int ic_p[2]  = '{1, 0};

  typedef struct {
    int          due;
    logic [15:0] d;
    logic [15:0] m;
  } rd_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] d;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        va;
    logic [15:0] da;
    logic        vb;
    logic [15:0] db;
  } vec_t;

  logic [15:0] mm [2][16];
  logic [1:0]  kn [2][16];
  int          busy_left [2];
  logic        exp_v [2];
  logic [15:0] exp_d [2];
  logic [15:0] exp_m [2];
  rd_t         qa[$];
  rd_t         qb[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_left[k] = (ic_p[k] != 0) ? dep_p[k] : 0;
      exp_v[k] = 1'b0;
      exp_d[k] = 16'h0000;
      exp_m[k] = 16'hFFFF;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step(input int k, input logic w, input logic [3:0] wa, input logic [15:0] d,
                            input logic [1:0] b, input logic r, input logic [3:0] ra);
    rd_t         e;
    logic [15:0] v;
    logic [15:0] m;
    if (busy_left[k] > 0) begin
      busy_left[k]--;
      if (busy_left[k] == 0) begin
        for (int a = 0; a < dep_p[k]; a++) begin
          mm[k][a] = 16'h0000;
          kn[k][a] = 2'b11;
        end
      end
    end else begin
      if (r) begin
        v = 16'h0000;
        m = 16'hFFFF;
        if (int'(ra) < dep_p[k]) begin
          for (int l = 0; l < 2; l++) begin
            if (wm_p[k] == 1 && w && wa == ra && b[l]) begin
              v[8*l +: 8] = d[8*l +: 8];
            end else begin
              v[8*l +: 8] = mm[k][ra][8*l +: 8];
              if (!kn[k][ra][l]) m[8*l +: 8] = 8'h00;
            end
          end
        end
        e.due = cyc + lat_p[k] - 1;
        e.d = v;
        e.m = m;
        if (k == 0) qa.push_back(e);
        else qb.push_back(e);
      end
      if (w && int'(wa) < dep_p[k]) begin
        for (int l = 0; l < 2; l++) begin
          if (b[l]) begin
            mm[k][wa][8*l +: 8] = d[8*l +: 8];
            kn[k][wa][l] = 1'b1;
          end
        end
      end
    end
    exp_v[k] = 1'b0;
    if (k == 0 && qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      exp_v[k] = 1'b1; exp_d[k] = e.d; exp_m[k] = e.m;
    end else if (k == 1 && qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      exp_v[k] = 1'b1; exp_d[k] = e.d; exp_m[k] = e.m;
    end
  endtask

  task automatic check_all();
    cmp("busy_a", 16'(busy_a), 16'(busy_left[0] > 0));
    cmp("rd_valid_a", 16'(rd_valid_a), 16'(exp_v[0]));
    cmp("d_out_a", d_out_a & exp_m[0], exp_d[0] & exp_m[0]);
    cmp("busy_b", 16'(busy_b), 16'(busy_left[1] > 0));
    cmp("rd_valid_b", 16'(rd_valid_b), 16'(exp_v[1]));
    cmp("d_out_b", d_out_b & exp_m[1], exp_d[1] & exp_m[1]);
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic cycle(input logic w, input logic [3:0] wa, input logic [15:0] d,
                       input logic [1:0] b, input logic r, input logic [3:0] ra);
    we = w; wr_addr = wa; d_in = d; be = b; re = r; rd_addr = ra;
    @(posedge clk);
    cyc++;
    model_step(0, w, wa, d, b, r, ra);
    model_step(1, w, wa, d, b, r, ra);
    #1;
    check_all();
    $display("cyc %0d we=%b wa=%h d=%h be=%b re=%b ra=%h | a: busy=%b v=%b d=%h | b: busy=%b v=%b d=%h",
             cyc, w, wa, d, b, r, ra, busy_a, rd_valid_a, d_out_a, busy_b, rd_valid_b, d_out_b);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 16'h0000, 2'b00, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    we = 1'b0; re = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs [14];

  initial begin
    int n;
    int pulses;
    logic        w, r;
    logic [3:0]  wa, ra;
    logic [15:0] d;
    logic [1:0]  b;

    vecs[0]  = '{1'b1, 4'h3, 16'hABCD, 2'b11, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 4'h3, 16'h1234, 2'b01, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h3, 1'b1, 16'hAB34, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 4'h3, 16'hFFFF, 2'b00, 1'b1, 4'h3, 1'b1, 16'hAB34, 1'b1, 16'hAB34};
    vecs[4]  = '{1'b1, 4'h5, 16'h1111, 2'b11, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b1, 16'hAB34};
    vecs[5]  = '{1'b1, 4'h5, 16'h2222, 2'b11, 1'b1, 4'h5, 1'b1, 16'h1111, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h5, 1'b1, 16'h2222, 1'b1, 16'h2222};
    vecs[7]  = '{1'b1, 4'h1, 16'h0F0F, 2'b11, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b1, 16'h2222};
    vecs[8]  = '{1'b1, 4'hD, 16'hFFFF, 2'b11, 1'b1, 4'hD, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h1, 1'b1, 16'h0F0F, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'hD, 1'b1, 16'hFFFF, 1'b1, 16'h0F0F};
    vecs[11] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h3, 1'b1, 16'hAB34, 1'b1, 16'h0000};
    vecs[12] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b1, 16'hAB34};
    vecs[13] = '{1'b0, 4'h0, 16'h0000, 2'b00, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000};

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) begin
        mm[k][a] = 16'h0000;
        kn[k][a] = 2'b00;
      end
    end

    @(negedge clk);
    do_reset();

    // Clear length after reset, then a back-to-back read sweep
    n = 0;
    while (busy_a && n < 40) begin
      idle();
      n++;
    end
    cmp("clear_edges", 16'(n), 16'd16);
    pulses = 0;
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'(a));
      if (rd_valid_a) pulses++;
    end
    cmp("sweep_pulses_a", 16'(pulses), 16'd16);
    idle();

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].we, vecs[i].wa, vecs[i].d, vecs[i].be, vecs[i].re, vecs[i].ra);
      cmp("tbl_valid_a", 16'(rd_valid_a), 16'(vecs[i].va));
      cmp("tbl_valid_b", 16'(rd_valid_b), 16'(vecs[i].vb));
      if (vecs[i].va) cmp("tbl_dout_a", d_out_a, vecs[i].da);
      if (vecs[i].vb) cmp("tbl_dout_b", d_out_b, vecs[i].db);
    end

    // Reset mid-clear, with requests issued while busy
    do_reset();
    for (int i = 0; i < 7; i++) idle();
    do_reset();
    n = 0;
    pulses = 0;
    while (busy_a && n < 40) begin
      cycle(1'b1, 4'h2, 16'hBEEF, 2'b11, 1'b1, 4'h2);
      if (rd_valid_a) pulses++;
      n++;
    end
    cmp("reclear_edges", 16'(n), 16'd16);
    cmp("busy_pulses_a", 16'(pulses), 16'd0);
    idle();
    idle();
    cycle(1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h2);
    cmp("busy_write_dropped_a", d_out_a, 16'h0000);
    cmp("busy_write_valid_a", 16'(rd_valid_a), 16'd1);
    // Contents of the no-clear instance survive reset
    cycle(1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, 4'h3);
    idle();
    cmp("survive_b", d_out_b, 16'hAB34);
    idle();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      d  = 16'($urandom);
      b  = 2'($urandom_range(0, 3));
      cycle(w, wa, d, b, r, ra);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sram_dp_bwe.md
Name: sram_dp_bwe

Overview:
Parametrised simple dual-port synchronous SRAM. It is the successor to the team's single-port sram: one write port and one independent read port, per-byte write enables, selectable read latency (1 or 2), and selectable read/write collision mode. A built-in clear state machine zeroes the array after reset, so downstream blocks no longer depend on $readmemb preload for a known state.

Parameters:
ADDR_WIDTH, 4, address width of both ports
WORD_DEPTH, 16, number of words; must be ≤ 2**ADDR_WIDTH
WORD_WIDTH, 16, word width in bits; must be a multiple of 8
READ_LATENCY, 1, read latency in clock edges; legal values 1 or 2
WRITE_MODE, 0, same-address collision result: 0 = read-first (old data), 1 = write-first (new merged data)
INIT_CLEAR, 1, 1 = zero the array after every reset; 0 = contents retained across reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
we  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
d_in  input  WORD_WIDTH  write data
be  input  WORD_WIDTH/8  byte-lane write enables; lane i = bits 8i+7:8i
re  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
d_out  output  WORD_WIDTH  registered read data
rd_valid  output  1  one-cycle pulse, d_out holds a new read result
busy  output  1  clear in progress; requests are ignored while high

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - d_out = 0, rd_valid = 0, read pipeline registers = 0, clr_cnt = 0.
  - FSM goes to CLEAR if INIT_CLEAR = 1 (busy = 1), else to IDLE (busy = 0).
  - Reset never modifies the array asynchronously.
- CLEAR state:
  - On each rising edge after rst deasserts: mem[clr_cnt] <= 0 and clr_cnt increments.
  - After the write to WORD_DEPTH-1, go to IDLE. busy drops on that same edge, so busy is high for exactly WORD_DEPTH edges.
  - rst asserted mid-clear restarts the clear from address 0.
- While busy = 1:
  - we and re are ignored: no writes, no reads, rd_valid = 0.
- Write (IDLE, we = 1):
  - For each i with be[i] = 1: mem[wr_addr][8i+7:8i] <= d_in[8i+7:8i].
  - Lanes with be[i] = 0 are unchanged.
  - be = 0 is a legal no-op.
- Read (IDLE, re = 1, sampled at edge N):
  - READ_LATENCY = 1: d_out updated and rd_valid = 1 after edge N.
  - READ_LATENCY = 2: d_out updated and rd_valid = 1 after edge N+1 (extra output register stage).
  - Fully pipelined: one read accepted per cycle, rd_valid asserted for every accepted read, in order.
  - d_out holds its last value when no read completes. rd_valid is high for one cycle per read.
- Collision (we and re both high, wr_addr == rd_addr, same edge):
  - WRITE_MODE = 0: read returns the pre-write word.
  - WRITE_MODE = 1: read returns the merged word (enabled lanes from d_in, other lanes from the old word).
  - The write is always performed.
- Out-of-range address (≥ WORD_DEPTH):
  - Writes are dropped with no aliasing.
  - Reads complete normally with rd_valid = 1 and d_out = 0.
- Simultaneous write and read to different addresses: fully independent.
- Parameter checks: an illegal READ_LATENCY, a WORD_WIDTH that is not a multiple of 8, or WORD_DEPTH > 2**ADDR_WIDTH must stop elaboration via a generate-time error.

Test Plan:
1. Clear after reset (defaults): pulse rst, count busy-high edges -> exactly 16; then read addresses 0..15 back-to-back -> 16 consecutive rd_valid pulses, d_out = 0x0000 each.
2. Byte enables: write 0xABCD, be = 2'b11, addr 3; then write 0x1234, be = 2'b01, addr 3; read addr 3 -> d_out = 0xAB34. Write with be = 2'b00 -> word unchanged.
3. Collision: mem[5] = 0x1111; same edge write 0x2222 (be = 11) and read addr 5 -> WRITE_MODE = 0 gives d_out = 0x1111; WRITE_MODE = 1 gives 0x2222. Follow-up read gives 0x2222 in both modes.
4. Latency: READ_LATENCY = 2, read addr 3 at edge N -> rd_valid high only after edge N+1, d_out = 0xAB34. Reads at N, N+1, N+2 -> three consecutive rd_valid pulses, in order.
5. Reset mid-clear: assert rst after 7 clear edges, release -> busy high for a further 16 edges; requests issued during busy produce no write and no rd_valid.
6. Out of range: WORD_DEPTH = 12; write 0xFFFF to addr 13 -> mem[1] and all others unchanged; read addr 13 -> rd_valid = 1, d_out = 0x0000. INIT_CLEAR = 0: data survives a reset pulse.
